// File: rtl/operand_regfile_pkg.sv
// Shared register-file defaults and the hardwired-zero register address,
// also used by the logic unit and ALU benches.
package operand_regfile_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_ADDR_W   = 5;

  localparam logic [DEF_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/operand_regfile_register.sv
// One architectural register: load-enabled storage cleared asynchronously by reset.
module operand_regfile_register #(
  parameter int WIDTH = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Storage with asynchronous clear; holds when not enabled.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_q <= {WIDTH{1'b0}};
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/operand_regfile.sv
// Operand register file feeding the logic unit: two combinational read ports,
// one synchronous write port, register 0 hardwired to zero, optional write bypass.
module operand_regfile
  import operand_regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int BYPASS   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_enable,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [WIDTH-1:0]  rs_data,
  output logic [WIDTH-1:0]  rt_data
);

  logic                 w_wr_ok;
  logic [NUM_REGS-1:1]  w_we;
  logic [WIDTH-1:0]     w_regs [NUM_REGS];

  // A write only counts when it can actually land in a real register.
  assign w_wr_ok = wr_enable && !reset && (wr_addr != ADDR_W'(REG_ZERO));

  assign w_regs[0] = {WIDTH{1'b0}};

  // One-hot write-enable decode.
  always_comb begin
    w_we = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (w_wr_ok && (wr_addr == ADDR_W'(i))) begin
        w_we[i] = 1'b1;
      end else begin
        w_we[i] = 1'b0;
      end
    end
  end

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
    operand_regfile_register #(.WIDTH(WIDTH)) u_reg (
      .i_clock (clock),
      .i_reset (reset),
      .i_en    (w_we[g]),
      .i_d     (wr_data),
      .o_q     (w_regs[g])
    );
  end

  // Port A: reset and address 0 force zero, bypass wins over stored value.
  always_comb begin
    rs_data = {WIDTH{1'b0}};
    if (reset || (rs_addr == ADDR_W'(REG_ZERO))) begin
      rs_data = {WIDTH{1'b0}};
    end else if ((BYPASS != 0) && w_wr_ok && (rs_addr == wr_addr)) begin
      rs_data = wr_data;
    end else begin
      rs_data = w_regs[rs_addr];
    end
  end

  // Port B: same selection rules as port A, evaluated independently.
  always_comb begin
    rt_data = {WIDTH{1'b0}};
    if (reset || (rt_addr == ADDR_W'(REG_ZERO))) begin
      rt_data = {WIDTH{1'b0}};
    end else if ((BYPASS != 0) && w_wr_ok && (rt_addr == wr_addr)) begin
      rt_data = wr_data;
    end else begin
      rt_data = w_regs[rt_addr];
    end
  end

endmodule

// File: tb/tb_operand_regfile.sv
// Directed bench for operand_regfile: bypassing and non-bypassing instances share stimulus.
module tb_operand_regfile;

  logic        clock;
  logic        reset;
  logic        wr_enable;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_b1, rt_b1, rs_b0, rt_b0;

  int n_checks = 0;
  int n_errors = 0;

  operand_regfile #(.BYPASS(1)) dut_b1 (
    .clock(clock), .reset(reset), .wr_enable(wr_enable), .wr_addr(wr_addr),
    .wr_data(wr_data), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_b1), .rt_data(rt_b1)
  );

  operand_regfile #(.BYPASS(0)) dut_b0 (
    .clock(clock), .reset(reset), .wr_enable(wr_enable), .wr_addr(wr_addr),
    .wr_data(wr_data), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_b0), .rt_data(rt_b0)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct packed {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rs1;
    logic [31:0] rt1;
    logic [31:0] rs0;
    logic [31:0] rt0;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check4(input string name, input logic [31:0] e_rs1, input logic [31:0] e_rt1,
                        input logic [31:0] e_rs0, input logic [31:0] e_rt0);
    check({name, " rs_byp"}, rs_b1, e_rs1);
    check({name, " rt_byp"}, rt_b1, e_rt1);
    check({name, " rs_nobyp"}, rs_b0, e_rs0);
    check({name, " rt_nobyp"}, rt_b0, e_rt0);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clock);
    wr_enable = 1'b1;
    wr_addr   = a;
    wr_data   = d;
    @(negedge clock);
    wr_enable = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_v;
    logic        cleared;

    // Vectors run back to back from an all-zero file; expectations sampled before the edge.
    vecs[0]  = '{1'b1, 5'd5, 32'h0000_00FF, 5'd5, 5'd4, 32'h0000_00FF, 32'h0, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 5'd5, 32'h0,         5'd5, 5'd5, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_00FF};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,         5'd4, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[3]  = '{1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[4]  = '{1'b0, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd5, 32'h0, 32'h0000_00FF, 32'h0, 32'h0000_00FF};
    vecs[5]  = '{1'b1, 5'd7, 32'h0000_1234, 5'd7, 5'd6, 32'h0000_1234, 32'h0, 32'h0, 32'h0};
    vecs[6]  = '{1'b1, 5'd7, 32'h0000_ABCD, 5'd7, 5'd7, 32'h0000_ABCD, 32'h0000_ABCD, 32'h0000_1234, 32'h0000_1234};
    vecs[7]  = '{1'b0, 5'd9, 32'h0000_0055, 5'd7, 5'd9, 32'h0000_ABCD, 32'h0, 32'h0000_ABCD, 32'h0};
    vecs[8]  = '{1'b0, 5'd9, 32'h0000_0055, 5'd9, 5'd9, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[9]  = '{1'b1, 5'd9, 32'h0000_0055, 5'd9, 5'd7, 32'h0000_0055, 32'h0000_ABCD, 32'h0, 32'h0000_ABCD};
    vecs[10] = '{1'b0, 5'd0, 32'h0,         5'd9, 5'd9, 32'h0000_0055, 32'h0000_0055, 32'h0000_0055, 32'h0000_0055};

    reset = 1'b1; wr_enable = 1'b0; wr_addr = 5'd0; wr_data = 32'h0;
    rs_addr = 5'd3; rt_addr = 5'd31;
    #2;
    check4("reset_state", 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      wr_enable = vecs[i].we;
      wr_addr   = vecs[i].wa;
      wr_data   = vecs[i].wd;
      rs_addr   = vecs[i].rs;
      rt_addr   = vecs[i].rt;
      #1;
      check4($sformatf("vec%0d", i), vecs[i].rs1, vecs[i].rt1, vecs[i].rs0, vecs[i].rt0);
    end
    @(negedge clock);
    wr_enable = 1'b0;

    // Asynchronous reset with no clock edge, writes ignored and bypass suppressed meanwhile.
    do_write(5'd3, 32'hDEAD_BEEF);
    rs_addr = 5'd3; rt_addr = 5'd3;
    #1;
    check4("pre_reset", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    #1;
    reset = 1'b1;
    wr_enable = 1'b1; wr_addr = 5'd3; wr_data = 32'h1111_1111;
    #1;
    check4("async_reset", 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clock);
    #1;
    check4("reset_write_ignored", 32'h0, 32'h0, 32'h0, 32'h0);
    #1;
    reset = 1'b0;
    #1;
    check4("reset_release_byp", 32'h1111_1111, 32'h1111_1111, 32'h0, 32'h0);
    @(negedge clock);
    wr_enable = 1'b0;
    #1;
    check4("first_write_after_release", 32'h1111_1111, 32'h1111_1111, 32'h1111_1111, 32'h1111_1111);

    // Fill every register, then sweep both ports with a reset pulse halfway through.
    for (int a = 1; a < 32; a++) begin
      do_write(5'(a), 32'(a) * 32'h0101_0101);
    end
    cleared = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clock);
      rs_addr = 5'(i);
      rt_addr = 5'(31 - i);
      if (i == 16) begin
        reset = 1'b1;
        #1;
        reset = 1'b0;
        cleared = 1'b1;
      end
      #1;
      exp_v = cleared ? 32'h0 : 32'(i) * 32'h0101_0101;
      check($sformatf("sweep rs_byp %0d", i), rs_b1, exp_v);
      check($sformatf("sweep rs_nobyp %0d", i), rs_b0, exp_v);
      exp_v = cleared ? 32'h0 : 32'(31 - i) * 32'h0101_0101;
      check($sformatf("sweep rt_byp %0d", 31 - i), rt_b1, exp_v);
      check($sformatf("sweep rt_nobyp %0d", 31 - i), rt_b0, exp_v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
